// File: rtl/pc_seq_pkg.sv
// -----------------------------------------------------------------------------
// pc_seq_pkg
// Shared definitions for the next-PC sequencer: controller state encoding,
// redirect source encoding, the default sequential increment and a small
// alignment helper used wherever a redirect target is about to be applied.
// No ports (package).
// -----------------------------------------------------------------------------
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } pcState_e;

  // Branch encodes higher than jump so a plain >= compare implements
  // "equal or higher priority may overwrite".
  typedef enum logic {
    SRC_JUMP   = 1'b0,
    SRC_BRANCH = 1'b1
  } redirSrc_e;

  localparam int unsigned PC_INC_DEFAULT = 4;

  function automatic logic isMisaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_seq_redirect_hold.sv
// -----------------------------------------------------------------------------
// pc_redirect_hold
// Pending-redirect register. Remembers a branch/jump target that arrived while
// the PC was stalled so it can be applied once the stall releases.
// Ports:
//   clk_i        clock
//   rst_ni       synchronous active-low reset (clears pending)
//   capture_i    controller allows a new request to be considered this cycle
//   reqValid_i   a redirect request is present
//   reqTarget_i  requested target address
//   reqSrc_i     requested source (jump / branch)
//   clear_i      pending redirect has been consumed
//   pendValid_o  a redirect is pending
//   pendTarget_o pending target address
//   pendSrc_o    pending source
// -----------------------------------------------------------------------------
module pc_redirect_hold
  import pc_seq_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        capture_i,
  input  logic        reqValid_i,
  input  logic [31:0] reqTarget_i,
  input  redirSrc_e   reqSrc_i,
  input  logic        clear_i,
  output logic        pendValid_o,
  output logic [31:0] pendTarget_o,
  output redirSrc_e   pendSrc_o
);

  logic        valid_q;
  logic [31:0] target_q;
  redirSrc_e   src_q;
  logic        accept;

  // A held branch is never displaced by a younger jump; anything else may
  // overwrite the slot (an empty slot always accepts).
  assign accept = capture_i && reqValid_i && (!valid_q || (reqSrc_i >= src_q));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      target_q <= 32'h0;
      src_q    <= SRC_JUMP;
    end else if (clear_i) begin
      valid_q  <= 1'b0;
      target_q <= 32'h0;
      src_q    <= SRC_JUMP;
    end else if (accept) begin
      valid_q  <= 1'b1;
      target_q <= reqTarget_i;
      src_q    <= reqSrc_i;
    end
  end

  assign pendValid_o  = valid_q;
  assign pendTarget_o = target_q;
  assign pendSrc_o    = src_q;

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Next-PC controller for the pipeline PC register. Chooses between sequential,
// branch and jump addresses, gates the PC load enable, holds redirects that
// arrive while stalled, flushes IF/ID on redirects and halts on request or on
// a misaligned target.
// Ports:
//   Clk          clock
//   Rst          synchronous active-low reset
//   PCIn         current PC value
//   Stall        hold the PC this cycle
//   BranchTaken  EX-stage branch resolved taken
//   BranchTarget EX-stage branch target
//   Jump         ID-stage jump / jr
//   JumpTarget   ID-stage jump target
//   Halt         ID-stage halt request
//   NextPC       address presented to the PC register
//   PCWrite      PC register load enable
//   FlushIFID    invalidate IF/ID this cycle
//   Halted       registered, high while halted
//   AddrError    registered, sticky misaligned-target flag
//   StallCount   registered, saturating count of non-writing RUN/STALL cycles
// -----------------------------------------------------------------------------
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned PC_INC       = PC_INC_DEFAULT,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [31:0]      PCIn,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [31:0]      BranchTarget,
  input  logic             Jump,
  input  logic [31:0]      JumpTarget,
  input  logic             Halt,
  output logic [31:0]      NextPC,
  output logic             PCWrite,
  output logic             FlushIFID,
  output logic             Halted,
  output logic             AddrError,
  output logic [CNT_W-1:0] StallCount
);

  pcState_e         state_q, state_d;
  logic             halted_q;
  logic             addrErr_q, addrErr_d;
  logic [CNT_W-1:0] stallCnt_q;

  logic             redirect;
  logic [31:0]      reqTarget;
  redirSrc_e        reqSrc;
  logic             capture;
  logic             clearPend;
  logic             pendValid;
  logic [31:0]      pendTarget;
  redirSrc_e        pendSrc;
  logic             cntInc;

  // The EX-stage branch is older than the ID-stage jump, so it wins.
  assign redirect  = BranchTaken || Jump;
  assign reqTarget = BranchTaken ? BranchTarget : JumpTarget;
  assign reqSrc    = BranchTaken ? SRC_BRANCH : SRC_JUMP;

  pc_redirect_hold uHold (
    .clk_i        (Clk),
    .rst_ni       (Rst),
    .capture_i    (capture),
    .reqValid_i   (redirect),
    .reqTarget_i  (reqTarget),
    .reqSrc_i     (reqSrc),
    .clear_i      (clearPend),
    .pendValid_o  (pendValid),
    .pendTarget_o (pendTarget),
    .pendSrc_o    (pendSrc)
  );

  // Next-state and PC-select logic. A STALL cycle with Stall low and nothing
  // pending falls through to the same decisions as RUN. A released pending
  // redirect drops any fresh request: those come from flushed instructions.
  always_comb begin
    NextPC    = PCIn + 32'(PC_INC);
    PCWrite   = 1'b0;
    FlushIFID = 1'b0;
    state_d   = state_q;
    addrErr_d = addrErr_q;
    capture   = 1'b0;
    clearPend = 1'b0;
    case (state_q)
      BOOT: begin
        NextPC    = RESET_VECTOR;
        PCWrite   = 1'b1;
        FlushIFID = 1'b1;
        state_d   = RUN;
      end
      RUN, STALL: begin
        if ((state_q == STALL) && Stall) begin
          capture = 1'b1;
        end else if ((state_q == STALL) && pendValid) begin
          clearPend = 1'b1;
          if (isMisaligned(pendTarget)) begin
            addrErr_d = 1'b1;
            state_d   = HALT;
          end else begin
            NextPC    = pendTarget;
            PCWrite   = 1'b1;
            FlushIFID = 1'b1;
            state_d   = RUN;
          end
        end else if (redirect) begin
          if (Stall) begin
            capture = 1'b1;
            state_d = STALL;
          end else if (isMisaligned(reqTarget)) begin
            addrErr_d = 1'b1;
            state_d   = HALT;
          end else begin
            NextPC    = reqTarget;
            PCWrite   = 1'b1;
            FlushIFID = 1'b1;
            state_d   = RUN;
          end
        end else if (Halt) begin
          state_d = HALT;
        end else if (Stall) begin
          state_d = STALL;
        end else begin
          PCWrite = 1'b1;
          state_d = RUN;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // Only RUN/STALL cycles that hold the PC are counted; saturate at all-ones.
  assign cntInc = ((state_q == RUN) || (state_q == STALL)) && !PCWrite &&
                  (stallCnt_q != {CNT_W{1'b1}});

  // State, status flags and counter registers.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q    <= BOOT;
      halted_q   <= 1'b0;
      addrErr_q  <= 1'b0;
      stallCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      halted_q  <= (state_d == HALT);
      addrErr_q <= addrErr_d;
      if (cntInc) begin
        stallCnt_q <= stallCnt_q + CNT_W'(1);
      end
    end
  end

  assign Halted     = halted_q;
  assign AddrError  = addrErr_q;
  assign StallCount = stallCnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench for pc_sequencer: a directed vector table, a hand-written
// misaligned-pending sequence, then randomized traffic against a reference
// model of the sequencing rules.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0040_0000;
  localparam int          CW = 4;

  logic          clk = 1'b0;
  logic          rst, stall, bt, jmp, halt;
  logic [31:0]   btgt, jtgt, pcin;
  logic [31:0]   nextPC;
  logic          pcWrite, flush, halted, addrErr;
  logic [CW-1:0] stallCount;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .RESET_VECTOR (RV),
    .PC_INC       (4),
    .CNT_W        (CW)
  ) dut (
    .Clk          (clk),
    .Rst          (rst),
    .PCIn         (pcin),
    .Stall        (stall),
    .BranchTaken  (bt),
    .BranchTarget (btgt),
    .Jump         (jmp),
    .JumpTarget   (jtgt),
    .Halt         (halt),
    .NextPC       (nextPC),
    .PCWrite      (pcWrite),
    .FlushIFID    (flush),
    .Halted       (halted),
    .AddrError    (addrErr),
    .StallCount   (stallCount)
  );

  typedef struct {
    logic        rst, stall, bt;
    logic [31:0] btgt;
    logic        jmp;
    logic [31:0] jtgt;
    logic        halt;
    logic [31:0] pcin;
    logic [31:0] expNext;
    logic        expWe, expFl, expHalted, expErr;
    logic [3:0]  expCnt;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic r, s, b, input logic [31:0] bT,
                              input logic j, input logic [31:0] jT, input logic h,
                              input logic [31:0] pc, input logic [31:0] eN,
                              input logic eW, eF, eH, eE, input logic [3:0] eC);
    vec_t v;
    v.rst = r; v.stall = s; v.bt = b; v.btgt = bT; v.jmp = j; v.jtgt = jT;
    v.halt = h; v.pcin = pc; v.expNext = eN; v.expWe = eW; v.expFl = eF;
    v.expHalted = eH; v.expErr = eE; v.expCnt = eC;
    return v;
  endfunction

  task automatic applyStimulus(input logic r, s, b, input logic [31:0] bT,
                               input logic j, input logic [31:0] jT, input logic h,
                               input logic [31:0] pc);
    rst = r; stall = s; bt = b; btgt = bT; jmp = j; jtgt = jT; halt = h; pcin = pc;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model state: boot pending, halted, error flag, stalled flag,
  // count and a single-entry pending queue.
  typedef struct packed {
    logic [31:0] t;
    logic        br;
  } pend_t;

  bit    mBoot, mHalted, mErr, mInStall;
  int    mCnt;
  pend_t pendQ[$];
  bit    nBoot, nHalted, nErr, nInStall;
  int    nCnt;
  pend_t nPend[$];

  task automatic modelEval(output logic [31:0] eNext, output logic eWe, output logic eFl);
    logic        redirect;
    pend_t       req;
    logic [31:0] t;
    logic        apply;
    redirect = bt || jmp;
    req.t    = bt ? btgt : jtgt;
    req.br   = bt;
    eNext = pcin + 32'd4; eWe = 1'b0; eFl = 1'b0;
    nBoot = mBoot; nHalted = mHalted; nErr = mErr; nInStall = mInStall;
    nCnt = mCnt; nPend = pendQ;
    apply = 1'b0; t = 32'h0;
    if (mHalted) begin
    end else if (mBoot) begin
      eNext = RV; eWe = 1'b1; eFl = 1'b1; nBoot = 1'b0;
    end else if (mInStall && stall) begin
      if (redirect) begin
        if (pendQ.size() == 0) nPend.push_back(req);
        else if (req.br || !pendQ[0].br) nPend[0] = req;
      end
    end else if (mInStall && pendQ.size() > 0) begin
      nPend.delete();
      apply = 1'b1; t = pendQ[0].t;
    end else if (redirect) begin
      if (stall) begin
        nPend.delete(); nPend.push_back(req); nInStall = 1'b1;
      end else begin
        apply = 1'b1; t = req.t;
      end
    end else if (halt) begin
      nHalted = 1'b1;
    end else if (stall) begin
      nInStall = 1'b1;
    end else begin
      eWe = 1'b1; nInStall = 1'b0;
    end
    if (apply) begin
      if (t[1:0] != 2'b00) begin
        nErr = 1'b1; nHalted = 1'b1;
      end else begin
        eNext = t; eWe = 1'b1; eFl = 1'b1; nInStall = 1'b0;
      end
    end
    if (!mBoot && !mHalted && !eWe && mCnt < 15) nCnt = mCnt + 1;
    if (!rst) begin
      nBoot = 1'b1; nHalted = 1'b0; nErr = 1'b0; nInStall = 1'b0; nCnt = 0;
      nPend.delete();
    end
  endtask

  task automatic modelCommit();
    mBoot = nBoot; mHalted = nHalted; mErr = nErr; mInStall = nInStall;
    mCnt = nCnt; pendQ = nPend;
  endtask

  initial begin
    logic [31:0] eNext, pcReg, r1, r2, ta, tb2;
    logic        eWe, eFl, rr, rs, rb, rj, rh;
    int          haltRun;

    // Directed table (RESET_VECTOR = 0x00400000).
    //                r  s  b  btgt          j  jtgt         h  pcin          expNext       W  F  H  E  cnt
    vecs[0]  = mk(1, 0, 0, 32'h0,        0, 32'h0,       0, 32'h0,        RV,           1, 1, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 32'h0,        0, 32'h0,       0, RV,           32'h0040_0004,1, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 1, 32'h300,      1, 32'h200,     0, 32'h100,      32'h300,      1, 1, 0, 0, 0);
    vecs[3]  = mk(1, 0, 0, 32'h0,        0, 32'h0,       0, 32'hFFFF_FFFC,32'h0,        1, 0, 0, 0, 0);
    vecs[4]  = mk(1, 1, 0, 32'h0,        1, 32'h40,      0, 32'h300,      32'h304,      0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 1, 1, 32'h80,       0, 32'h0,       0, 32'h300,      32'h304,      0, 0, 0, 0, 1);
    vecs[6]  = mk(1, 1, 0, 32'h0,        1, 32'h44,      0, 32'h300,      32'h304,      0, 0, 0, 0, 2);
    vecs[7]  = mk(1, 0, 0, 32'h0,        1, 32'h500,     0, 32'h300,      32'h80,       1, 1, 0, 0, 3);
    vecs[8]  = mk(1, 0, 0, 32'h0,        0, 32'h0,       0, 32'h80,       32'h84,       1, 0, 0, 0, 3);
    vecs[9]  = mk(1, 0, 1, 32'h102,      0, 32'h0,       0, 32'h80,       32'h84,       0, 0, 0, 0, 3);
    vecs[10] = mk(1, 0, 0, 32'h0,        0, 32'h0,       0, 32'h80,       32'h84,       0, 0, 1, 1, 4);
    vecs[11] = mk(1, 0, 1, 32'h200,      0, 32'h0,       0, 32'h80,       32'h84,       0, 0, 1, 1, 4);
    vecs[12] = mk(0, 0, 0, 32'h0,        0, 32'h0,       0, 32'h80,       32'h84,       0, 0, 1, 1, 4);
    vecs[13] = mk(1, 0, 0, 32'h0,        0, 32'h0,       0, 32'h80,       RV,           1, 1, 0, 0, 0);
    vecs[14] = mk(1, 0, 0, 32'h0,        0, 32'h0,       1, RV,           32'h0040_0004,0, 0, 0, 0, 0);
    vecs[15] = mk(1, 0, 0, 32'h0,        0, 32'h0,       0, RV,           32'h0040_0004,0, 0, 1, 0, 1);
    vecs[16] = mk(0, 0, 0, 32'h0,        0, 32'h0,       0, RV,           32'h0040_0004,0, 0, 1, 0, 1);
    vecs[17] = mk(1, 0, 0, 32'h0,        0, 32'h0,       0, 32'h0,        RV,           1, 1, 0, 0, 0);
    vecs[18] = mk(1, 1, 1, 32'h900,      0, 32'h0,       0, RV,           32'h0040_0004,0, 0, 0, 0, 0);
    vecs[19] = mk(0, 1, 0, 32'h0,        0, 32'h0,       0, RV,           32'h0040_0004,0, 0, 0, 0, 1);
    vecs[20] = mk(1, 0, 0, 32'h0,        0, 32'h0,       0, RV,           RV,           1, 1, 0, 0, 0);
    vecs[21] = mk(1, 0, 0, 32'h0,        0, 32'h0,       0, RV,           32'h0040_0004,1, 0, 0, 0, 0);

    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].rst, vecs[i].stall, vecs[i].bt, vecs[i].btgt,
                    vecs[i].jmp, vecs[i].jtgt, vecs[i].halt, vecs[i].pcin);
      #1;
      if (vecs[i].expWe) checkOutput($sformatf("row%0d NextPC", i), nextPC, vecs[i].expNext);
      checkOutput($sformatf("row%0d PCWrite", i), 32'(pcWrite), 32'(vecs[i].expWe));
      checkOutput($sformatf("row%0d FlushIFID", i), 32'(flush), 32'(vecs[i].expFl));
      checkOutput($sformatf("row%0d Halted", i), 32'(halted), 32'(vecs[i].expHalted));
      checkOutput($sformatf("row%0d AddrError", i), 32'(addrErr), 32'(vecs[i].expErr));
      checkOutput($sformatf("row%0d StallCount", i), 32'(stallCount), 32'(vecs[i].expCnt));
    end

    // Misaligned jump captured during a stall, detected only when released.
    @(negedge clk); applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0, RV);
    @(negedge clk); applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0, RV);
    @(negedge clk); applyStimulus(1, 1, 0, 32'h0, 1, 32'h41, 0, RV);
    #1 checkOutput("misalignCapture PCWrite", 32'(pcWrite), 32'd0);
    @(negedge clk); applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0, RV);
    #1 checkOutput("misalignRelease PCWrite", 32'(pcWrite), 32'd0);
    checkOutput("misalignRelease FlushIFID", 32'(flush), 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); applyStimulus(1, 0, (k % 2) == 0, 32'h800, 0, 32'h0, 0, RV);
      #1 checkOutput($sformatf("halt%0d PCWrite", k), 32'(pcWrite), 32'd0);
      checkOutput($sformatf("halt%0d Halted", k), 32'(halted), 32'd1);
      checkOutput($sformatf("halt%0d AddrError", k), 32'(addrErr), 32'd1);
    end
    @(negedge clk); applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0, RV);
    @(negedge clk); applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h1234);
    #1 checkOutput("rebootNextPC", nextPC, RV);
    checkOutput("rebootHalted", 32'(halted), 32'd0);
    checkOutput("rebootAddrError", 32'(addrErr), 32'd0);

    // Randomized traffic against the reference model, starting from reset.
    @(negedge clk); applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0, RV);
    @(posedge clk);
    mBoot = 1'b1; mHalted = 1'b0; mErr = 1'b0; mInStall = 1'b0; mCnt = 0;
    pendQ.delete();
    pcReg   = RV;
    haltRun = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      r1 = $urandom(); r2 = $urandom();
      ta  = {r1[31:2], 2'b00};
      tb2 = {r2[31:2], 2'b00};
      if ($urandom_range(24) == 0) ta[1:0]  = 2'($urandom_range(3, 1));
      if ($urandom_range(24) == 0) tb2[1:0] = 2'($urandom_range(3, 1));
      if ($urandom_range(30) == 0) tb2 = 32'hFFFF_FFFC;
      rs = ($urandom_range(99) < 40);
      rb = ($urandom_range(99) < 15);
      rj = ($urandom_range(99) < 15);
      rh = !rs && ($urandom_range(99) < 3);
      rr = !((haltRun > 4) || ($urandom_range(99) < 2));
      applyStimulus(rr, rs, rb, ta, rj, tb2, rh, pcReg);
      #1;
      modelEval(eNext, eWe, eFl);
      if (eWe) checkOutput($sformatf("rand%0d NextPC", c), nextPC, eNext);
      checkOutput($sformatf("rand%0d PCWrite", c), 32'(pcWrite), 32'(eWe));
      checkOutput($sformatf("rand%0d FlushIFID", c), 32'(flush), 32'(eFl));
      checkOutput($sformatf("rand%0d Halted", c), 32'(halted), 32'(mHalted));
      checkOutput($sformatf("rand%0d AddrError", c), 32'(addrErr), 32'(mErr));
      checkOutput($sformatf("rand%0d StallCount", c), 32'(stallCount), 32'(mCnt));
      @(posedge clk);
      modelCommit();
      if (eWe) pcReg = eNext;
      haltRun = mHalted ? haltRun + 1 : 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
